// File: rtl/seq_code_pkg.sv
// Shared types and helpers for the sequence code counter.
// Johnson encoding is compiled in only when SEQ_CODE_COUNTER_JOHNSON_EN is defined.
package seq_code_pkg;

    localparam int unsigned MAX_WIDTH = 16;
    localparam int unsigned IDX_MAX_W = MAX_WIDTH + 1;

    typedef enum logic [1:0] {
        MODE_BIN     = 2'b00,
        MODE_GRAY    = 2'b01,
        MODE_JOHNSON = 2'b10,
        MODE_RSVD    = 2'b11
    } mode_t;

    // Modes that actually count in this build.
    function automatic logic mode_is_valid(mode_t m);
        logic v;
        v = 1'b0;
        case (m)
            MODE_BIN, MODE_GRAY: v = 1'b1;
`ifdef SEQ_CODE_COUNTER_JOHNSON_EN
            MODE_JOHNSON:        v = 1'b1;
`endif
            default:             v = 1'b0;
        endcase
        return v;
    endfunction

    // Sequence length L for a mode at width w (0 for non-counting modes).
    function automatic logic [IDX_MAX_W-1:0] seq_len(mode_t m, int unsigned w);
        logic [IDX_MAX_W-1:0] len;
        len = '0;
        case (m)
            MODE_BIN, MODE_GRAY: len = IDX_MAX_W'(1) << w;
`ifdef SEQ_CODE_COUNTER_JOHNSON_EN
            MODE_JOHNSON:        len = IDX_MAX_W'(2 * w);
`endif
            default:             len = '0;
        endcase
        return len;
    endfunction

    // Output code for a binary index, masked to w bits.
    function automatic logic [MAX_WIDTH-1:0] seq_encode(logic [IDX_MAX_W-1:0] idx,
                                                        mode_t m, int unsigned w);
        logic [31:0] mask;
        logic [31:0] k;
        logic [31:0] code;
        mask = (32'd1 << w) - 32'd1;
        k    = 32'(idx);
        code = '0;
        case (m)
            MODE_BIN:  code = k;
            MODE_GRAY: code = k ^ (k >> 1);
`ifdef SEQ_CODE_COUNTER_JOHNSON_EN
            MODE_JOHNSON: begin
                if (k < w) code = (32'd1 << k) - 32'd1;
                else       code = ~((32'd1 << (k - w)) - 32'd1);
            end
`endif
            default:   code = '0;
        endcase
        return MAX_WIDTH'(code & mask);
    endfunction

endpackage

// File: rtl/seq_code_step.sv
// Combinational next-index, wrap and terminal-count logic for seq_code_counter.
module seq_code_step
    import seq_code_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned IW    = WIDTH
) (
    input  logic [IW-1:0] idx,
    input  logic          dir,
    input  mode_t         mode,
    output logic [IW-1:0] idx_next,
    output logic          tc
);

    logic [IDX_MAX_W-1:0] len;
    logic [IDX_MAX_W-1:0] last;
    logic [IDX_MAX_W-1:0] cur;
    logic [IDX_MAX_W-1:0] step;

    // Step the index by one modulo L in the requested direction; flag the terminal state.
    always_comb begin
        len  = seq_len(mode, WIDTH);
        last = len - IDX_MAX_W'(1);
        cur  = IDX_MAX_W'(idx);
        step = cur;
        if (!dir) begin
            // >= also folds a stale out-of-range index back to 0
            step = (cur >= last) ? '0 : cur + IDX_MAX_W'(1);
        end else begin
            step = (cur == '0) ? last : cur - IDX_MAX_W'(1);
        end
        idx_next = IW'(step);
        tc       = mode_is_valid(mode) && (dir ? (cur == '0) : (cur == last));
    end

endmodule

// File: rtl/seq_code_counter.sv
// Parametrised up/down sequence counter with binary, Gray and Johnson output codes.
// Define SEQ_CODE_COUNTER_JOHNSON_EN to compile in Johnson mode (mode 10);
// otherwise mode 10 is treated as reserved.
module seq_code_counter
    import seq_code_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    input  logic             dir,
    input  logic [1:0]       mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             err
);

`ifdef SEQ_CODE_COUNTER_JOHNSON_EN
    localparam int unsigned IW = WIDTH + 1;
`else
    localparam int unsigned IW = WIDTH;
`endif

    mode_t         mode_in;
    mode_t         mode_q;
    logic [IW-1:0] idx;
    logic [IW-1:0] idx_next;
    logic [IW-1:0] load_idx;
    logic          load_oor;

    assign mode_in  = mode_t'(mode);
    assign load_idx = IW'(load_val);

`ifdef SEQ_CODE_COUNTER_JOHNSON_EN
    assign load_oor = (mode_in == MODE_JOHNSON) && (32'(load_val) >= 2 * WIDTH);
`else
    assign load_oor = 1'b0;
`endif

    seq_code_step #(
        .WIDTH (WIDTH),
        .IW    (IW)
    ) u_step (
        .idx      (idx),
        .dir      (dir),
        .mode     (mode_in),
        .idx_next (idx_next),
        .tc       (tc)
    );

    function automatic logic [WIDTH-1:0] code_of(logic [IW-1:0] i, mode_t m);
        return WIDTH'(seq_encode(IDX_MAX_W'(i), m, WIDTH));
    endfunction

    // Index/code/error registers with priority clr > mode change > reserved > load > en.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            idx    <= '0;
            q      <= '0;
            mode_q <= MODE_BIN;
            err    <= 1'b0;
        end else if (mode_in != mode_q) begin
            // Every code maps index 0 to all-zeros. Switching into a
            // non-counting mode restarts at 0 and flags it in one edge.
            mode_q <= mode_in;
            idx    <= '0;
            q      <= '0;
            if (!mode_is_valid(mode_in)) err <= 1'b1;
        end else if (!mode_is_valid(mode_in)) begin
            err <= 1'b1;
        end else if (load) begin
            if (load_oor) begin
                idx <= '0;
                q   <= '0;
                err <= 1'b1;
            end else begin
                idx <= load_idx;
                q   <= code_of(load_idx, mode_in);
            end
        end else if (en) begin
            idx <= idx_next;
            q   <= code_of(idx_next, mode_in);
        end
    end

endmodule

// File: tb/tb_seq_code_counter.sv
// Randomized self-checking bench for seq_code_counter (WIDTH=4) against a
// sequence-level reference model.
module tb_seq_code_counter;

    localparam int unsigned W = 4;
`ifdef SEQ_CODE_COUNTER_JOHNSON_EN
    localparam bit JOHN = 1'b1;
`else
    localparam bit JOHN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         clr = 1'b0;
    logic         en = 1'b0;
    logic         dir = 1'b0;
    logic [1:0]   mode = 2'b00;
    logic         load = 1'b0;
    logic [W-1:0] load_val = '0;
    logic [W-1:0] q;
    logic         tc;
    logic         err;

    int n_chk  = 0;
    int n_pass = 0;

    // reference model state
    int m_idx = 0;
    int m_q   = 0;
    int m_mq  = 0;
    int m_err = 0;

    seq_code_counter #(.WIDTH(W)) dut (
        .clk      (clk),
        .clr      (clr),
        .en       (en),
        .dir      (dir),
        .mode     (mode),
        .load     (load),
        .load_val (load_val),
        .q        (q),
        .tc       (tc),
        .err      (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    function automatic int m_len(int md);
        if (md < 2) return 16;
        if (md == 2 && JOHN) return 2 * W;
        return 0;
    endfunction

    // Code for position k: binary, Gray, or k shifts of a twisted ring from all-zeros.
    function automatic int m_code(int k, int md);
        int r;
        if (md == 0) return k;
        if (md == 1) return k ^ (k >> 1);
        r = 0;
        for (int i = 0; i < k; i++) r = ((r << 1) | (((r >> (W - 1)) & 1) ^ 1)) & ((1 << W) - 1);
        return r;
    endfunction

    function automatic int m_tc();
        int l;
        l = m_len(mode);
        if (l == 0) return 0;
        return dir ? int'(m_idx == 0) : int'(m_idx == l - 1);
    endfunction

    task automatic model_reset();
        m_idx = 0; m_q = 0; m_mq = 0; m_err = 0;
    endtask

    task automatic model_edge();
        int l;
        l = m_len(mode);
        if (int'(mode) != m_mq) begin
            m_mq = mode; m_idx = 0; m_q = 0;
            if (l == 0) m_err = 1;
        end else if (l == 0) begin
            m_err = 1;
        end else if (load) begin
            if (int'(load_val) >= l) begin
                m_idx = 0; m_err = 1;
            end else begin
                m_idx = load_val;
            end
            m_q = m_code(m_idx, mode);
        end else if (en) begin
            m_idx = dir ? (m_idx + l - 1) % l : (m_idx + 1) % l;
            m_q = m_code(m_idx, mode);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, "_q"},   int'(q),   m_q);
        check({tag, "_err"}, int'(err), m_err);
        check({tag, "_tc"},  int'(tc),  m_tc());
    endtask

    // One clock edge, then compare away from the edge.
    task automatic cyc(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    // Asynchronous clear pulsed between edges; call right after cyc().
    task automatic pulse_clr();
        #2 clr = 1'b1;
        #1 model_reset();
        check_all("clr");
        check("clr_q0", int'(q), 0);
        check("clr_err0", int'(err), 0);
        #1 clr = 1'b0;
    endtask

    initial begin
        // reset
        #1 clr = 1'b1;
        #1 model_reset();
        check_all("rst");
        check("rst_tc", int'(tc), int'(dir));
        @(posedge clk);
        #1 clr = 1'b0;

        // binary up, full wrap
        mode = 2'b00; dir = 1'b0; en = 1'b1;
        repeat (16) cyc("bin");
        check("bin_wrap", int'(q), 0);

        // Gray up: first edge is the mode change
        mode = 2'b01;
        cyc("gray_sw");
        repeat (15) cyc("gray");
        check("gray_end_q", int'(q), 4'b1000);
        check("gray_end_tc", int'(tc), 1);
        cyc("gray_wrap");
        check("gray_wrap_q", int'(q), 0);

        // load beats en
        load = 1'b1; load_val = 4'd9;
        cyc("gray_load");
        check("gray_load_q", int'(q), 4'b1101);
        load = 1'b0;

`ifdef SEQ_CODE_COUNTER_JOHNSON_EN
        mode = 2'b10; en = 1'b0;
        cyc("john_sw");
        load = 1'b1; load_val = 4'd12;
        cyc("john_oor");
        check("john_oor_q", int'(q), 0);
        check("john_oor_err", int'(err), 1);
        load = 1'b0;
        pulse_clr();
        dir = 1'b1;
        cyc("john_sw2");
        check("john_tc0", int'(tc), 1);
        en = 1'b1;
        cyc("john_dn1");
        check("john_dn1_q", int'(q), 4'b1000);
        cyc("john_dn2");
        check("john_dn2_q", int'(q), 4'b1100);
`else
        mode = 2'b10;
        cyc("m10_rsvd");
        check("m10_err", int'(err), 1);
        check("m10_tc", int'(tc), 0);
        pulse_clr();
`endif

        // mode change mid-count restarts
        mode = 2'b00; dir = 1'b0; en = 1'b1; load = 1'b1; load_val = 4'd5;
        cyc("bin_ld5");
        check("bin_ld5_q", int'(q), 4'b0101);
        load = 1'b0; mode = 2'b01;
        cyc("sw_gray");
        check("sw_gray_q", int'(q), 0);
        cyc("sw_gray_step");
        check("sw_gray_step_q", int'(q), 4'b0001);

        // clr mid-count, then reserved mode
        mode = 2'b00; en = 1'b0; load = 1'b1; load_val = 4'd10;
        cyc("bin_ld10");
        cyc("bin_ld10b");
        check("bin_ld10_q", int'(q), 4'b1010);
        load = 1'b0;
        pulse_clr();
        mode = 2'b11; en = 1'b1;
        cyc("rsvd1");
        check("rsvd_err", int'(err), 1);
        cyc("rsvd2");
        check("rsvd_hold_q", int'(q), 0);
        check("rsvd_tc", int'(tc), 0);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 9) == 0) mode = 2'($urandom_range(0, 3));
            en       = ($urandom_range(0, 9) < 7);
            dir      = 1'($urandom);
            load     = ($urandom_range(0, 9) < 2);
            load_val = W'($urandom);
            cyc("rnd");
            if ($urandom_range(0, 39) == 0) pulse_clr();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/seq_code_counter.md
# seq_code_counter

Parametrised synchronous sequence counter, the next generation of the team's fixed 4-bit sequence counter. A single binary index register is stepped up or down, and the registered output is encoded as plain binary, reflected Gray, or Johnson (twisted-ring) code. It adds load, enable, direction and terminal-count signalling, and serves as the shared counter for sequencing and display logic in lab designs.

## Interface
- WIDTH, 4, output/code width in bits; legal range 2..16
- clk  in  1  rising-edge clock
- clr  in  1  asynchronous, active-high reset
- en  in  1  advance one step this cycle
- dir  in  1  0 = up, 1 = down
- mode  in  2  00 binary, 01 Gray, 10 Johnson, 11 reserved
- load  in  1  synchronous load of index from load_val
- load_val  in  WIDTH  index to load (binary index, not code)
- q  out  WIDTH  registered encoded count
- tc  out  1  terminal count for current dir/mode (combinational)
- err  out  1  registered sticky flag: reserved mode seen, or out-of-range Johnson load

## Operation
- Internal state: idx (binary index, WIDTH+1 bits wide to cover Johnson length 2·WIDTH), mode_q (last mode), q, err.
- Sequence length L: 2^WIDTH for binary/Gray; 2·WIDTH for Johnson.
- Encoding of idx:
  - binary: q = idx
  - Gray: q = idx ^ (idx >> 1)
  - Johnson: for k < WIDTH, q = (1<<k)-1; for k ≥ WIDTH, q = ~((1<<(k-WIDTH))-1), masked to WIDTH bits. For WIDTH=4: 0000, 0001, 0011, 0111, 1111, 1110, 1100, 1000.
- Per-edge priority, highest first:
  1. clr
  2. mode change (mode ≠ mode_q): idx ← 0, q ← code(0)
  3. load: idx ← load_val; in Johnson mode, a load_val ≥ 2·WIDTH loads 0 and sets err
  4. en: idx ← idx ± 1 modulo L
  5. otherwise hold
- Wrap-around: up from L-1 goes to 0; down from 0 goes to L-1.
- tc = (dir==0 && idx==L-1) || (dir==1 && idx==0). tc does not depend on en.
- mode 11: idx and q hold, err is set, tc = 0.
- err clears only on clr.

## Timing
- Asynchronous reset: clr high immediately forces idx=0, q=0, mode_q=00, err=0. tc then equals dir.
- Release of clr is synchronous to clk, with no extra settle cycle. The first en edge after release steps the counter.
- Latency: q reflects load, step or mode change one clk edge after the inputs are sampled. tc follows idx in the same cycle.
- A dir change takes effect on the next stepping edge. No reload occurs.
- load and en in the same cycle: load wins and no step is taken.
- clr mid-count at any state returns to 0 without waiting for a clock edge.

## Configuration
- SEQ_CODE_COUNTER_JOHNSON_EN
  - Defined: mode 10 selects Johnson encoding with L = 2·WIDTH, and idx is WIDTH+1 bits.
  - Undefined: Johnson logic is not compiled in. mode 10 behaves as reserved (hold, set err), and idx is WIDTH bits.

## Structure
- Package seq_code_pkg holds:
  - mode enum: MODE_BIN, MODE_GRAY, MODE_JOHNSON, MODE_RSVD
  - encode function (idx, mode, WIDTH)
  - length function L(mode, WIDTH)
- Sub-module seq_code_step is natural: a purely combinational next-idx/wrap/tc computation. The top module keeps the registers and the priority logic.

## Test plan
- WIDTH=4, binary, dir=0, en held for 16 cycles from reset → q steps 1..15 then 0; tc high only while q=15.
- Gray up from 0 for 15 steps → q = 0001, 0011, 0010, 0110, … ending at 1000 with tc=1; next step → 0000.
- Johnson (macro defined), dir=1 from reset → tc=1 at idx 0; one en edge → q=1000 (idx 7); then 1100.
- Gray: load=1, load_val=9 and en=1 in the same cycle → q=1101 (idx 9, no step); a Johnson load of 12 → q=0000 and err=1.
- Binary count at q=0101, mode switched to Gray → next edge q=0000; following en edge → q=0001.
- clr pulsed between edges at q=1010 → q=0000 and err=0 immediately; mode=11 afterwards → q holds and err=1 on the next edge.
